// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM skid register: FSM states, control-bit
// bundle and occupancy encodings.
package ex_mem_pkg;

  localparam int unsigned OCC_W = 2;

  localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] OCC_FULL  = 2'd1;
  localparam logic [OCC_W-1:0] OCC_SKID  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  // Control bits carried with every bundle; the width-dependent payload
  // struct is built around this in the top level.
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  // Occupancy is a pure function of the state, never a counter.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      EMPTY:   return OCC_EMPTY;
      FULL:    return OCC_FULL;
      SKID:    return OCC_SKID;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_payload_bank.sv
// One bundle-wide register with synchronous clear (priority) and load.
// Ports: clk, rst (async, active-high), clr_i, ld_i, d_i[W], q_o[W].
module ex_mem_payload_bank #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] bank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else if (clr_i) begin
      bank_q <= '0;
    end else if (ld_i) begin
      bank_q <= d_i;
    end
  end

  assign q_o = bank_q;

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with valid/ready handshake and a one-entry
// skid buffer. Outputs always show the main bank; the skid bank absorbs
// one bundle when MEM stalls, so in_ready is registered and never
// depends combinationally on out_ready.
// Ports: clk, rst, flush; EX side in_valid/in_ready + control/payload;
//        MEM side out_valid/out_ready + registered control/payload;
//        occ (0..2), ctrl_err (sticky illegal read+write control).
module ex_mem_skid_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEST_W      = 5,
  parameter bit          R0_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] ST_val_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] ST_val,
  output logic [DEST_W-1:0] Dest,
  output logic [OCC_W-1:0]  occ,
  output logic              ctrl_err
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
    logic [DEST_W-1:0] dest;
  } bundle_t;

  localparam int unsigned BUNDLE_W = $bits(bundle_t);

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q, ctrl_err_q;
  logic [OCC_W-1:0] occ_q;

  logic    accept_c, pop_c;
  logic    main_ld_c, main_clr_c, skid_ld_c, skid_clr_c;
  bundle_t in_bundle_c, main_d_c, main_q, skid_q;

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = out_valid_q & out_ready;

  // Incoming bundle; writes to R0 are turned into no-writeback here.
  always_comb begin
    in_bundle_c                = '0;
    in_bundle_c.ctrl.wb_en     = WB_en_in &
                                 ((R0_SUPPRESS == 1'b0) || (Dest_in != '0));
    in_bundle_c.ctrl.mem_r_en  = MEM_R_EN_in;
    in_bundle_c.ctrl.mem_w_en  = MEM_W_EN_in;
    in_bundle_c.pc             = PC_in;
    in_bundle_c.alu_result     = ALU_result_in;
    in_bundle_c.st_val         = ST_val_in;
    in_bundle_c.dest           = Dest_in;
  end

  // Next state and bank strobes; flush overrides accept and pop.
  always_comb begin
    state_d    = state_q;
    main_ld_c  = 1'b0;
    main_clr_c = 1'b0;
    skid_ld_c  = 1'b0;
    skid_clr_c = 1'b0;
    main_d_c   = in_bundle_c;
    if (flush) begin
      state_d    = EMPTY;
      main_clr_c = 1'b1;
      skid_clr_c = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d   = FULL;
            main_ld_c = 1'b1;
          end
        end
        FULL: begin
          if (accept_c && pop_c) begin
            main_ld_c = 1'b1;
          end else if (accept_c) begin
            state_d   = SKID;
            skid_ld_c = 1'b1;
          end else if (pop_c) begin
            // Going empty leaves a bubble: zeroed controls on the outputs.
            state_d    = EMPTY;
            main_clr_c = 1'b1;
          end
        end
        SKID: begin
          if (pop_c) begin
            state_d    = FULL;
            main_ld_c  = 1'b1;
            main_d_c   = skid_q;
            skid_clr_c = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clr_c = 1'b1;
          skid_clr_c = 1'b1;
        end
      endcase
    end
  end

  // State plus registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= OCC_EMPTY;
      ctrl_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_of(state_d);
      // A flushed input is dropped, so it cannot raise the error either.
      if (!flush && accept_c && MEM_R_EN_in && MEM_W_EN_in) begin
        ctrl_err_q <= 1'b1;
      end
    end
  end

  ex_mem_payload_bank #(.W(BUNDLE_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr_i (main_clr_c),
    .ld_i  (main_ld_c),
    .d_i   (main_d_c),
    .q_o   (main_q)
  );

  ex_mem_payload_bank #(.W(BUNDLE_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr_i (skid_clr_c),
    .ld_i  (skid_ld_c),
    .d_i   (in_bundle_c),
    .q_o   (skid_q)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign occ        = occ_q;
  assign ctrl_err   = ctrl_err_q;
  assign WB_en      = main_q.ctrl.wb_en;
  assign MEM_R_EN   = main_q.ctrl.mem_r_en;
  assign MEM_W_EN   = main_q.ctrl.mem_w_en;
  assign PC         = main_q.pc;
  assign ALU_result = main_q.alu_result;
  assign ST_val     = main_q.st_val;
  assign Dest       = main_q.dest;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios then random traffic, all
// checked against a queue-based model of a two-deep FIFO stage.
module tb_ex_mem_skid_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic          wb_in, rd_in, wr_in;
  logic [DW-1:0] pc_in, alu_in, st_in;
  logic [RW-1:0] dest_in;

  logic          in_ready, out_valid, WB_en, MEM_R_EN, MEM_W_EN, ctrl_err;
  logic [DW-1:0] PC, ALU_result, ST_val;
  logic [RW-1:0] Dest;
  logic [1:0]    occ;

  logic          n_in_ready, n_out_valid, n_WB_en, n_MEM_R_EN, n_MEM_W_EN, n_ctrl_err;
  logic [DW-1:0] n_PC, n_ALU_result, n_ST_val;
  logic [RW-1:0] n_Dest;
  logic [1:0]    n_occ;

  ex_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW), .R0_SUPPRESS(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
    .PC_in(pc_in), .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .PC(PC), .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest),
    .occ(occ), .ctrl_err(ctrl_err)
  );

  ex_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW), .R0_SUPPRESS(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .WB_en_in(wb_in), .MEM_R_EN_in(rd_in), .MEM_W_EN_in(wr_in),
    .PC_in(pc_in), .ALU_result_in(alu_in), .ST_val_in(st_in), .Dest_in(dest_in),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .WB_en(n_WB_en), .MEM_R_EN(n_MEM_R_EN), .MEM_W_EN(n_MEM_W_EN),
    .PC(n_PC), .ALU_result(n_ALU_result), .ST_val(n_ST_val), .Dest(n_Dest),
    .occ(n_occ), .ctrl_err(n_ctrl_err)
  );

  typedef struct packed {
    logic          wb;
    logic          rd;
    logic          wr;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic [RW-1:0] dest;
  } ref_t;

  // Model: the stage is a FIFO of at most two bundles plus a sticky flag.
  ref_t mq[$];
  logic m_err;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    ref_t e;
    logic v;
    v = (mq.size() > 0);
    e = v ? mq[0] : '0;
    check("out_valid", 128'(out_valid), 128'(v));
    check("in_ready",  128'(in_ready),  128'(mq.size() < 2));
    check("occ",       128'(occ),       128'(mq.size()));
    check("ctrl_err",  128'(ctrl_err),  128'(m_err));
    check("WB_en",     128'(WB_en),     128'(e.wb && (e.dest != '0)));
    check("MEM_ctrl",  128'({MEM_R_EN, MEM_W_EN}), 128'({e.rd, e.wr}));
    check("PC",        128'(PC),         128'(e.pc));
    check("ALU_result",128'(ALU_result), 128'(e.alu));
    check("ST_val",    128'(ST_val),     128'(e.st));
    check("Dest",      128'(Dest),       128'(e.dest));
    check("nr_WB_en",  128'(n_WB_en),    128'(e.wb));
    check("nr_all",
          128'({n_out_valid, n_in_ready, n_occ, n_ctrl_err, n_MEM_R_EN, n_MEM_W_EN,
                n_PC, n_ALU_result, n_ST_val, n_Dest}),
          128'({v, (mq.size() < 2), 2'(mq.size()), m_err, e.rd, e.wr,
                e.pc, e.alu, e.st, e.dest}));
  endtask

  task automatic model_step();
    logic acc, pop;
    ref_t b;
    acc = in_valid && (mq.size() < 2);
    pop = out_ready && (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        b = '{wb: wb_in, rd: rd_in, wr: wr_in, pc: pc_in, alu: alu_in, st: st_in, dest: dest_in};
        mq.push_back(b);
        if (rd_in && wr_in) m_err = 1'b1;
      end
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the
  // falling edge, then the model advances for the coming rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ordy, input logic fl,
                       input logic wb, input logic rd, input logic wr,
                       input logic [DW-1:0] alu, input logic [RW-1:0] d);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    wb_in     = wb;
    rd_in     = rd;
    wr_in     = wr;
    pc_in     = 32'h1000 + alu;
    alu_in    = alu;
    st_in     = ~alu;
    dest_in   = d;
  endtask

  // Asynchronous reset in the middle of a cycle; effect must be immediate.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_occ",       128'(occ),       128'(0));
    check("rst_payload",   128'({WB_en, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest}), 128'(0));
    check("rst_ctrl_err",  128'(ctrl_err),  128'(0));
    mq.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    m_err = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Streaming: four back-to-back bundles with MEM always ready.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10 + 32'(i), 5'd3);
      cycle();
      check("stream_alu", 128'(ALU_result), 128'(32'h10 + 32'(i)));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    repeat (2) cycle();

    // Backpressure: A and B fill the stage, C waits upstream.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA, 5'd4);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB, 5'd4);
    cycle();
    check("bp_occ",      128'(occ),      128'(2));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC, 5'd4);
    cycle();
    check("bp_hold_A", 128'(ALU_result), 128'(32'hA));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC, 5'd4);
    cycle();
    check("bp_then_B", 128'(ALU_result), 128'(32'hB));
    cycle();
    check("bp_then_C", 128'(ALU_result), 128'(32'hC));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    repeat (2) cycle();

    // Flush while in SKID with a concurrent valid input and a pop.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 5'd9);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 5'd9);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h23, 5'd9);
    cycle();
    check("flush_occ",   128'(occ),       128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_wb",    128'(WB_en),     128'(0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    repeat (2) cycle();

    // R0 writeback suppression (second instance has it disabled).
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 5'd0);
    cycle();
    check("r0_wb",    128'(WB_en),   128'(0));
    check("r0_nr_wb", 128'(n_WB_en), 128'(1));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h31, 5'd7);
    cycle();
    check("r7_wb", 128'(WB_en), 128'(1));

    // Illegal read+write control: sticky through flush, cleared by reset.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 5'd2);
    cycle();
    check("err_set", 128'(ctrl_err), 128'(1));
    check("err_bundle_kept", 128'({MEM_R_EN, MEM_W_EN}), 128'(2'b11));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    cycle();
    check("err_after_flush", 128'(ctrl_err), 128'(1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    cycle();

    // Mid-stream reset with data in both banks.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h50, 5'd1);
    cycle();
    cycle();
    do_reset();
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic fl, ill, rd, wr;
      logic [RW-1:0] d;
      fl  = ($urandom_range(0, 31) == 0);
      ill = !fl && ($urandom_range(0, 19) == 0);
      rd  = ill ? 1'b1 : 1'($urandom_range(0, 1));
      wr  = ill ? 1'b1 : (!rd && ($urandom_range(0, 1) == 1));
      d   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), fl,
            1'($urandom_range(0, 1)), rd, wr, 32'($urandom), d);
      pc_in = 32'($urandom);
      st_in = 32'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
